// File: rtl/adder0_accum.sv
`default_nettype none
// ============================================================================
// Module      : adder0_accum
// Description : Burst accumulate stage wrapped around the combinational 8-bit
//               adder0. The block takes LEN samples on a valid/ready input
//               stream and sums them modulo 256. It rebuilds each carry-out
//               from the adder operands and sum, because adder0 does not
//               provide one, and counts them. The result is then held on a
//               valid/ready output until the consumer accepts it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: ADDER0_ACCUM_SAT_EN
//   When defined, a handshake that produces a carry-out loads 0xFF into the
//   accumulator instead of the wrapped sum, so the result saturates.
//   When undefined, the accumulator wraps modulo 256.
// ----------------------------------------------------------------------------
// Ports:
//   wb_clk_i     in   1      clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      begin a burst (sampled in IDLE only)
//   len          in   LEN_W  burst length, sampled with start
//   in_valid     in   1      sample valid
//   in_data      in   8      sample value
//   in_ready     out  1      sample accepted this cycle (ACCUM)
//   add_a        out  8      adder0 a_in
//   add_b        out  8      adder0 b_in
//   add_sum      in   8      adder0 sum (combinational)
//   out_valid    out  1      result valid (HOLD)
//   out_ready    in   1      consumer accepts result
//   out_data     out  8      accumulated sum
//   out_carries  out  LEN_W  number of carry-outs during the burst
//   busy         out  1      any state other than IDLE
// ============================================================================
module adder0_accum #(
  parameter int LEN_W = 4
) (
  input  logic             wb_clk_i,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  input  logic [7:0]       add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [LEN_W-1:0] out_carries,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [LEN_W-1:0] carries_q, carries_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;

  logic             carry_out;
  logic             accept;

  // Adder operands. Outside ACCUM the b operand is zero, and add_sum is ignored.
  assign add_a = acc_q;
  assign add_b = (state_q == S_ACCUM) ? in_data : 8'h00;

  // Carry-out of an 8-bit add, derived from the operand and sum MSBs. Both
  // operands set means a carry. Operands that differ in the MSB carry only
  // when the sum MSB has cleared.
  assign carry_out = (add_a[7] & add_b[7]) | ((add_a[7] ^ add_b[7]) & ~add_sum[7]);

  assign in_ready    = (state_q == S_ACCUM);
  assign out_valid   = (state_q == S_HOLD);
  assign busy        = (state_q != S_IDLE);
  assign out_data    = acc_q;
  assign out_carries = carries_q;

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    carries_d   = carries_q;
    remaining_d = remaining_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d     = 8'h00;
          carries_d = '0;
          if (len != '0) begin
            remaining_d = len;
            state_d     = S_ACCUM;
          end else begin
            state_d = S_HOLD;
          end
        end
      end

      S_ACCUM: begin
        if (accept) begin
`ifdef ADDER0_ACCUM_SAT_EN
          acc_d = carry_out ? 8'hFF : add_sum;
`else
          acc_d = add_sum;
`endif
          carries_d   = carries_q + LEN_W'(carry_out);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= 8'h00;
      carries_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carries_q   <= carries_d;
      remaining_q <= remaining_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adder0_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder0_accum
// Description : Self-checking bench for adder0_accum. It provides a
//               behavioural stand-in for adder0, an arithmetic reference
//               model, and directed bursts with literal expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder0_accum;

  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             out_ready = 1'b0;
  wire              in_ready;
  wire  [7:0]       add_a;
  wire  [7:0]       add_b;
  wire  [7:0]       add_sum;
  wire              out_valid;
  wire  [7:0]       out_data;
  wire  [LEN_W-1:0] out_carries;
  wire              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // adder0 itself: plain 8-bit combinational add.
  assign add_sum = add_a + add_b;

  adder0_accum #(.LEN_W(LEN_W)) dut (
    .wb_clk_i   (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_sum    (add_sum),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_carries(out_carries),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_phase: 0 = waiting for a start, 1 = taking samples,
  // 2 = result pending. By default the result is the integer total of the
  // accepted samples: the total modulo 256 gives the data, and the total
  // divided by 256 gives the carry count. The saturating build steps the
  // accumulator one sample at a time.
  // ---------------------------------------------------------------------------
  int         m_phase = 0;
  int         m_left  = 0;
  int         m_total = 0;
  int         m_carr  = 0;
  logic [7:0] m_acc   = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_total = 0; m_carr = 0; m_acc = 8'h00;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_total = 0; m_carr = 0; m_acc = 8'h00;
          if (len == 0) m_phase = 2;
          else begin m_left = int'(len); m_phase = 1; end
        end
        1: if (in_valid) begin
          m_total = m_total + int'(in_data);
          if (int'(m_acc) + int'(in_data) > 255) begin
            m_carr++;
`ifdef ADDER0_ACCUM_SAT_EN
            m_acc = 8'hFF;
`else
            m_acc = m_acc + in_data;
`endif
          end else begin
            m_acc = m_acc + in_data;
          end
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  function automatic logic [7:0] exp_acc();
`ifdef ADDER0_ACCUM_SAT_EN
    return m_acc;
`else
    return 8'(m_total % 256);
`endif
  endfunction

  function automatic logic [31:0] exp_carr();
`ifdef ADDER0_ACCUM_SAT_EN
    return 32'(m_carr);
`else
    return 32'(m_total / 256);
`endif
  endfunction

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    chk("in_ready",  in_ready,  m_phase == 1);
    chk("out_valid", out_valid, m_phase == 2);
    chk("busy",      busy,      m_phase != 0);
    chk("add_a",     add_a,     exp_acc());
    chk("add_b",     add_b,     (m_phase == 1) ? in_data : 8'h00);
    if (m_phase == 2) begin
      chk("out_data",    out_data,    exp_acc());
      chk("out_carries", out_carries, exp_carr());
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_burst(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_out_data",  out_data,  8'h00);
    chk("rst_carries",   out_carries, 4'd0);
    #2 rst_n = 1'b1;
    tick();

    // Three back-to-back samples. The result is valid right after the third beat.
    begin_burst(3);
    send(8'h10); send(8'h20); send(8'h30);
    chk("t1_latency", out_valid, 1'b1);
    chk("t1_data",    out_data,  8'h60);
    chk("t1_carries", out_carries, 4'd0);
    accept_result();
    chk("t1_idle", busy, 1'b0);

    // A single carry-out.
    begin_burst(2);
    send(8'hF0); send(8'h20);
    chk("t2_valid", out_valid, 1'b1);
`ifdef ADDER0_ACCUM_SAT_EN
    chk("t2_data", out_data, 8'hFF);
`else
    chk("t2_data", out_data, 8'h10);
`endif
    chk("t2_carries", out_carries, 4'd1);
    accept_result();

    // Zero-length burst goes straight to the result.
    begin_burst(0);
    chk("t3_valid",    out_valid, 1'b1);
    chk("t3_in_ready", in_ready,  1'b0);
    chk("t3_data",     out_data,  8'h00);
    chk("t3_carries",  out_carries, 4'd0);
    accept_result();

    // 0xFF x4 with gaps. The result is held, and start is ignored meanwhile.
    begin_burst(4);
    for (int i = 0; i < 4; i++) begin
      send(8'hFF);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; len = LEN_W'(3); end
      tick();
      start = 1'b0;
      chk("t4_hold_valid", out_valid, 1'b1);
`ifdef ADDER0_ACCUM_SAT_EN
      chk("t4_hold_data", out_data, 8'hFF);
`else
      chk("t4_hold_data", out_data, 8'hFC);
`endif
      chk("t4_hold_carries", out_carries, 4'd3);
    end
    accept_result();
    chk("t4_idle_busy",  busy,     1'b0);
    chk("t4_idle_ready", in_ready, 1'b0);

    // Reset in the middle of a burst, then start a fresh burst.
    begin_burst(5);
    send(8'h01); send(8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy",    busy,      1'b0);
    chk("t5_rst_ready",   in_ready,  1'b0);
    chk("t5_rst_valid",   out_valid, 1'b0);
    chk("t5_rst_data",    out_data,  8'h00);
    chk("t5_rst_carries", out_carries, 4'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    begin_burst(1);
    send(8'h07);
    chk("t5_valid",   out_valid, 1'b1);
    chk("t5_data",    out_data,  8'h07);
    chk("t5_carries", out_carries, 4'd0);
    accept_result();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder0_accum.md
Name: adder0_accum

Overview:
- Sequential accumulate stage wrapped around the combinational 8-bit `adder0`. It feeds the adder's `a_in`/`b_in` and consumes its `sum` output.
- Accepts a burst of N 8-bit samples on a valid/ready stream and sums them modulo 256. Carry-outs are reconstructed and counted, because `adder0` exposes none.
- Presents the result on a valid/ready output. Sits between the user-project stimulus logic and the result readback registers.

Parameters:
- LEN_W, 4, width of burst-length field and carry counter; max burst = 2^LEN_W-1 samples.

Ports:
- wb_clk_i  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- len  input  LEN_W  number of samples in the burst; sampled with start.
- in_valid  input  1  sample valid.
- in_data  input  8  sample value.
- in_ready  output  1  block accepts a sample this cycle.
- add_a  output  8  to adder0 a_in.
- add_b  output  8  to adder0 b_in.
- add_sum  input  8  from adder0 sum (combinational, same cycle).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  8  accumulated sum mod 256.
- out_carries  output  LEN_W  number of 8-bit carry-outs during the burst.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; acc=0x00; carries=0; remaining=0.
  - Outputs: in_ready=0, out_valid=0, out_data=0x00, out_carries=0, busy=0.
  - Reset mid-burst discards all partial state; no result is produced.
- States: IDLE, ACCUM, HOLD.
- IDLE:
  - start=1 and len!=0: acc<=0, carries<=0, remaining<=len, go to ACCUM.
  - start=1 and len==0: acc<=0, carries<=0, go to HOLD; result 0x00 is valid the next cycle.
- ACCUM:
  - in_ready=1 (combinational from state).
  - add_a=acc, add_b=in_data.
  - On in_valid&in_ready: acc<=add_sum, remaining<=remaining-1, carries<=carries+c.
  - c=(add_a[7]&add_b[7])|((add_a[7]^add_b[7])&~add_sum[7]).
  - The handshake with remaining==1 transitions to HOLD.
  - in_valid gaps simply stall; there is no timeout.
- HOLD:
  - out_valid=1; out_data=acc; out_carries=carries, all stable until accepted.
  - On out_ready: go to IDLE.
- Outside ACCUM: add_a=acc, add_b=0x00, so add_sum is unused.
- start while busy is ignored and not queued.
- Latency: out_valid asserts the cycle after the last sample handshake; throughput is 1 sample/cycle.
- out_valid may not depend combinationally on out_ready; in_ready may not depend on in_valid.
- carries cannot overflow, since carries <= len <= 2^LEN_W-1.
- adder0 is combinational; its path (acc -> adder0 -> acc) is a single-cycle path.

Optional Feature:
- Macro ADDER0_ACCUM_SAT_EN.
- Defined: on a handshake where c=1, acc<=0xFF instead of add_sum. Once acc=0xFF, it holds 0xFF for any further nonzero sample. carries still increments per c, with c computed from the actual adder operands.
- Undefined: wrap-around mod 256 as described above.

Test Plan:
- len=3, samples 0x10,0x20,0x30 back-to-back -> out_valid 1 cycle after third beat, out_data=0x60, out_carries=0.
- len=2, samples 0xF0,0x20 -> out_data=0x10, out_carries=1. With ADDER0_ACCUM_SAT_EN: out_data=0xFF, out_carries=1.
- len=0 with start -> out_valid next cycle, out_data=0x00, out_carries=0; no in_ready pulse.
- len=4, samples 0xFF x4 with in_valid low every other cycle:
  - result out_data=0xFC, out_carries=3.
  - Hold out_ready low 5 cycles: outputs stable; a start pulse during HOLD is ignored.
  - Then out_ready=1 -> IDLE.
- len=5, deassert rst_n after 2 accepted samples -> all outputs 0 immediately. A new burst (len=1, sample 0x07) then yields out_data=0x07, out_carries=0.
